fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the decoder. Generates the program counter and issues in-order word requests to instruction memory over a valid/ready channel. Buffers returned instruction words with their PCs in a small reservation buffer and presents them to decode as `inst_encoding`/`inst_pc` with a valid/ready handshake. Accepts a redirect from the jump path (JAL/JALR resolution), flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit
// Brief    : In-order instruction fetch with a small reservation buffer and
//            redirect flush. The FETCH_MISALIGN_CHECK_EN macro enables a sticky
//            misaligned-target flag that also halts fetch.
// Revision : 1.0
// =============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_encoding,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign
);

  localparam int                PTR_W        = $clog2(BUF_DEPTH);
  localparam int                CNT_W        = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C      = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W:0]    INFLIGHT_MAX = (CNT_W+1)'(2*BUF_DEPTH - 1);

  logic [31:0]          fetch_pc;
  logic [31:0]          ent_pc   [BUF_DEPTH];
  logic [31:0]          ent_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] ent_filled;
  logic [BUF_DEPTH-1:0] filled_nxt;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [PTR_W-1:0]     fill_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     unfilled;
  logic [CNT_W-1:0]     drop_cnt;
  logic [CNT_W-1:0]     redirect_drop;
  logic [CNT_W:0]       inflight;
  logic [31:0]          target_pc;
  logic                 halted;
  logic                 pop;
  logic                 alloc;
  logic                 rsp_fill;
  logic                 rsp_drop;
  logic                 room;
  logic                 inflight_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_pc = redirect_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00))
      halted <= 1'b1;
  end
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign target_pc      = {redirect_pc[31:2], 2'b00};
  assign halted         = 1'b0;
`endif

  assign misalign      = halted;

  assign inst_valid    = (count != '0) && ent_filled[head];
  assign inst_encoding = inst_valid ? ent_data[head] : 32'h0;
  assign inst_pc       = inst_valid ? ent_pc[head]   : 32'h0;
  assign pop           = inst_valid && inst_ready;

  // Stale plus live in-flight words are capped so drop_cnt can never overflow
  // across back-to-back redirects.
  assign room          = (count != DEPTH_C) || pop;
  assign inflight      = {1'b0, unfilled} + {1'b0, drop_cnt};
  assign inflight_ok   = inflight < INFLIGHT_MAX;

  assign imem_req_valid = !rst && !redirect && !halted && room && inflight_ok;
  assign imem_req_addr  = fetch_pc;
  assign alloc          = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill       = imem_rsp_valid && (drop_cnt == '0);
  assign redirect_drop  = unfilled + drop_cnt - CNT_W'(imem_rsp_valid);

  always_comb begin
    filled_nxt = ent_filled;
    if (pop)      filled_nxt[head]     = 1'b0;
    if (alloc)    filled_nxt[tail]     = 1'b0;
    if (rsp_fill) filled_nxt[fill_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      unfilled   <= '0;
      drop_cnt   <= '0;
      ent_filled <= '0;
    end else if (redirect) begin
      fetch_pc   <= target_pc;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      unfilled   <= '0;
      drop_cnt   <= redirect_drop;
      ent_filled <= '0;
    end else begin
      if (alloc) begin
        fetch_pc <= fetch_pc + 32'd4;
        tail     <= tail + PTR_W'(1);
      end
      if (pop)      head     <= head + PTR_W'(1);
      if (rsp_fill) fill_ptr <= fill_ptr + PTR_W'(1);
      if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
      count      <= count + CNT_W'(alloc) - CNT_W'(pop);
      unfilled   <= unfilled + CNT_W'(alloc) - CNT_W'(rsp_fill);
      ent_filled <= filled_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!redirect) begin
      if (alloc)    ent_pc[tail]       <= fetch_pc;
      if (rsp_fill) ent_data[fill_ptr] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire
